// File: rtl/ram_bist_ctrl_if.sv
// RAM-side bus of the BIST sequencer: the sequencer is the master and the RAM is the slave.
interface ram_bist_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              ram_ce_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i;

    modport master (
        output ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o,
        input  ram_rdata_i
    );

    modport slave (
        input  ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/ram_bist_ctrl.sv
// RAM BIST sequencer: write pattern, read back, compare, report pass/fail and error stats.
// Optional abort input enabled by defining RAM_BIST_ABORT_EN.
module ram_bist_ctrl #(
    parameter int         ADDR_W = 8,
    parameter int         DATA_W = 8,
    parameter int         RD_LAT = 1,
    parameter logic [7:0] SEED   = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
`ifdef RAM_BIST_ABORT_EN
    input  logic              abort_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ADDR_W-1:0] err_cnt_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
    output logic [4:0]        cstate_o,
    ram_bist_ctrl_if.master   ram
);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_WRITE = 5'b00010,
        S_READ  = 5'b00100,
        S_DRAIN = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
    localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT - 1);

    // Fibonacci LFSR, taps x^8+x^6+x^5+x^4, shifting toward the MSB.
    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        mode,
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        lfsr
    );
        case (mode)
            2'd0:    return DATA_W'(addr);
            2'd1:    return ~DATA_W'(addr);
            2'd2:    return DATA_W'(lfsr);
            default: return addr[0] ? DATA_W'(8'hAA) : DATA_W'(8'h55);
        endcase
    endfunction

    state_t            r_state;
    logic [1:0]        r_mode;
    logic [7:0]        r_lfsr;
    logic              r_ram_ce;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [DATA_W-1:0] r_rd_exp;
    logic [2:0]        r_drain_cnt;
    logic              r_pass;
    logic [ADDR_W-1:0] r_err_cnt;
    logic [ADDR_W-1:0] r_first_err;
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [ADDR_W-1:0] r_pipe_addr [RD_LAT];
    logic [DATA_W-1:0] r_pipe_exp  [RD_LAT];

    logic              w_abort;
    logic              w_cmp_err;
    logic [ADDR_W-1:0] w_err_cnt_nxt;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [7:0]        w_lfsr_inc;

`ifdef RAM_BIST_ABORT_EN
    assign w_abort = abort_i && (r_state inside {S_WRITE, S_READ, S_DRAIN});
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_cmp_err     = r_pipe_vld[RD_LAT-1] && !w_abort &&
                        (ram.ram_rdata_i != r_pipe_exp[RD_LAT-1]);
        w_err_cnt_nxt = r_err_cnt;
        if (w_cmp_err && (r_err_cnt != '1)) begin
            w_err_cnt_nxt = r_err_cnt + 1'b1;
        end
        w_addr_inc    = r_ram_addr + 1'b1;
        w_lfsr_inc    = lfsr_step(r_lfsr);
    end

    // NOTE: only the valid bits need reset; address/expected data are don't-care while invalid.
    always_ff @(posedge clk_i) begin
        r_pipe_addr[0] <= r_ram_addr;
        r_pipe_exp[0]  <= r_rd_exp;
        for (int i = 1; i < RD_LAT; i++) begin
            r_pipe_addr[i] <= r_pipe_addr[i-1];
            r_pipe_exp[i]  <= r_pipe_exp[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_mode      <= '0;
            r_lfsr      <= SEED;
            r_ram_ce    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_rd_exp    <= '0;
            r_drain_cnt <= '0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_pipe_vld  <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
            r_pipe_vld[0] <= (r_state == S_READ);

            r_err_cnt <= w_err_cnt_nxt;
            // A saturating counter never returns to zero, so zero means no mismatch yet this run.
            if (w_cmp_err && (r_err_cnt == '0)) begin
                r_first_err <= r_pipe_addr[RD_LAT-1];
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state     <= S_WRITE;
                        r_mode      <= mode_i;
                        r_err_cnt   <= '0;
                        r_first_err <= '0;
                        r_pass      <= 1'b0;
                        r_lfsr      <= SEED;
                        r_ram_ce    <= 1'b1;
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= '0;
                        r_ram_wdata <= pattern(mode_i, '0, SEED);
                    end
                end
                S_WRITE: begin
                    if (r_ram_addr == LAST_ADDR) begin
                        r_state     <= S_READ;
                        r_ram_we    <= 1'b0;
                        r_ram_addr  <= '0;
                        r_ram_wdata <= '0;
                        r_lfsr      <= SEED;
                        r_rd_exp    <= pattern(r_mode, '0, SEED);
                    end else begin
                        r_ram_addr  <= w_addr_inc;
                        r_lfsr      <= w_lfsr_inc;
                        r_ram_wdata <= pattern(r_mode, w_addr_inc, w_lfsr_inc);
                    end
                end
                S_READ: begin
                    if (r_ram_addr == LAST_ADDR) begin
                        r_state     <= S_DRAIN;
                        r_ram_ce    <= 1'b0;
                        r_drain_cnt <= '0;
                    end else begin
                        r_ram_addr <= w_addr_inc;
                        r_lfsr     <= w_lfsr_inc;
                        r_rd_exp   <= pattern(r_mode, w_addr_inc, w_lfsr_inc);
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state <= S_DONE;
                        r_pass  <= (w_err_cnt_nxt == '0);
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // NOTE: placed after the case so these non-blocking assignments win over the FSM's.
            if (w_abort) begin
                r_state    <= S_DONE;
                r_ram_ce   <= 1'b0;
                r_ram_we   <= 1'b0;
                r_pipe_vld <= '0;
                r_pass     <= 1'b0;
            end
        end
    end

    assign cstate_o         = r_state;
    assign busy_o           = ~r_state[0];
    assign done_o           = r_state[4];
    assign pass_o           = r_pass;
    assign err_cnt_o        = r_err_cnt;
    assign first_err_addr_o = r_first_err;

    assign ram.ram_ce_o    = r_ram_ce;
    assign ram.ram_we_o    = r_ram_we;
    assign ram.ram_addr_o  = r_ram_addr;
    assign ram.ram_wdata_o = r_ram_wdata;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: two instances (read latency 1 and 3) run in lockstep against RAM models
// with injectable faults; results are predicted from a pattern table built from the pattern rules.
module tb_ram_bist_ctrl;

    localparam int N = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i;
    logic       start_i;
    logic [1:0] mode_i;
`ifdef RAM_BIST_ABORT_EN
    logic       abort_i;
`endif

    logic [1:0]      busy, done, pass, ce, we;
    logic [1:0][7:0] err_cnt, first_err, addr, wdata;
    logic [1:0][4:0] cstate;

    ram_bist_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
    ram_bist_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

    ram_bist_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .SEED(8'hA5)) u_dut_l1 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
`ifdef RAM_BIST_ABORT_EN
        .abort_i(abort_i),
`endif
        .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .err_cnt_o(err_cnt[0]),
        .first_err_addr_o(first_err[0]), .cstate_o(cstate[0]), .ram(bus0)
    );

    ram_bist_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3), .SEED(8'hA5)) u_dut_l3 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
`ifdef RAM_BIST_ABORT_EN
        .abort_i(abort_i),
`endif
        .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .err_cnt_o(err_cnt[1]),
        .first_err_addr_o(first_err[1]), .cstate_o(cstate[1]), .ram(bus1)
    );

    assign ce[0] = bus0.ram_ce_o;   assign ce[1] = bus1.ram_ce_o;
    assign we[0] = bus0.ram_we_o;   assign we[1] = bus1.ram_we_o;
    assign addr[0] = bus0.ram_addr_o;   assign addr[1] = bus1.ram_addr_o;
    assign wdata[0] = bus0.ram_wdata_o; assign wdata[1] = bus1.ram_wdata_o;

    // Fault injection: 0 none, 1 single stuck bit at one address, 2 every read returns f_val.
    int         f_kind = 0;
    logic [7:0] f_addr = 8'h00;
    logic [2:0] f_bit  = 3'd0;
    logic       f_stuck = 1'b0;
    logic [7:0] f_val  = 8'hFF;

    function automatic logic [7:0] ram_view(input logic [7:0] a, input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (f_kind == 1 && a == f_addr) r[f_bit] = f_stuck;
        else if (f_kind == 2) r = f_val;
        return r;
    endfunction

    logic [7:0] mem0 [N];
    logic [7:0] mem1 [N];
    logic [7:0] rp0;
    logic [7:0] rp1 [3];

    always @(posedge clk) begin
        if (bus0.ram_ce_o && bus0.ram_we_o) mem0[bus0.ram_addr_o] <= bus0.ram_wdata_o;
        if (bus1.ram_ce_o && bus1.ram_we_o) mem1[bus1.ram_addr_o] <= bus1.ram_wdata_o;
        rp0    <= (bus0.ram_ce_o && !bus0.ram_we_o) ? ram_view(bus0.ram_addr_o, mem0[bus0.ram_addr_o]) : 8'h00;
        rp1[0] <= (bus1.ram_ce_o && !bus1.ram_we_o) ? ram_view(bus1.ram_addr_o, mem1[bus1.ram_addr_o]) : 8'h00;
        rp1[1] <= rp1[0];
        rp1[2] <= rp1[1];
    end
    assign bus0.ram_rdata_i = rp0;
    assign bus1.ram_rdata_i = rp1[2];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: expected word per address and the resulting run summary.
    logic [7:0] pat [N];
    int         exp_err;
    int         exp_first;
    logic       exp_pass;

    task automatic build_model(input logic [1:0] mode);
        int s;
        int found;
        s = 'hA5;
        for (int a = 0; a < N; a++) begin
            case (mode)
                2'd0: pat[a] = 8'(a);
                2'd1: pat[a] = 8'(255 - a);
                2'd2: begin
                    pat[a] = 8'(s);
                    s = ((s << 1) & 255) | (((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1);
                end
                default: pat[a] = (a % 2 == 1) ? 8'hAA : 8'h55;
            endcase
        end
        exp_err = 0;
        exp_first = 0;
        found = 0;
        for (int a = 0; a < N; a++) begin
            if (ram_view(8'(a), pat[a]) != pat[a]) begin
                exp_err++;
                if (found == 0) begin
                    exp_first = a;
                    found = 1;
                end
            end
        end
        if (exp_err > 255) exp_err = 255;
        exp_pass = (exp_err == 0);
    endtask

    task automatic run_test(input logic [1:0] mode, input int kind, input logic [7:0] fa,
                            input logic [2:0] fb, input logic fs, input logic glitch);
        int         done_cyc [2];
        int         done_w   [2];
        int         wr_cnt   [2];
        int         wr_bad   [2];
        int         viol     [2];
        logic [7:0] got_err  [2];
        logic [7:0] got_first[2];
        logic       got_pass [2];
        f_kind = kind; f_addr = fa; f_bit = fb; f_stuck = fs;
        build_model(mode);
        for (int d = 0; d < 2; d++) begin
            done_cyc[d] = 0; done_w[d] = 0; wr_cnt[d] = 0; wr_bad[d] = 0; viol[d] = 0;
            got_err[d] = 8'h00; got_first[d] = 8'h00; got_pass[d] = 1'b0;
        end
        @(negedge clk);
        mode_i = mode;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        mode_i = ~mode;
        for (int cyc = 1; cyc <= 530; cyc++) begin
            @(negedge clk);
            start_i = glitch && cyc >= 10 && cyc <= 500 && ($urandom_range(0, 7) == 0);
            if (glitch) mode_i = 2'($urandom);
            if (cyc == 1) begin
                check("start_clears_err", err_cnt[0], 0);
                check("start_clears_first", first_err[0], 0);
                check("start_clears_pass", pass[0], 0);
                check("wdata_addr0", wdata[0], pat[0]);
            end
            if (cyc == 2) check("wdata_addr1", wdata[0], pat[1]);
            for (int d = 0; d < 2; d++) begin
                if (ce[d] && we[d]) begin
                    if (addr[d] != 8'(wr_cnt[d]) || wdata[d] != pat[addr[d]]) wr_bad[d]++;
                    wr_cnt[d]++;
                end
                if (we[d] && cstate[d] != 5'b00010) viol[d]++;
                if (ce[d] && cstate[d] != 5'b00010 && cstate[d] != 5'b00100) viol[d]++;
                if (done[d]) begin
                    done_w[d]++;
                    if (done_cyc[d] == 0) begin
                        done_cyc[d]  = cyc;
                        got_err[d]   = err_cnt[d];
                        got_first[d] = first_err[d];
                        got_pass[d]  = pass[d];
                    end
                end
            end
        end
        start_i = 1'b0;
        for (int d = 0; d < 2; d++) begin
            int lat;
            lat = (d == 0) ? 1 : 3;
            check($sformatf("L%0d_m%0d_done_cycle", lat, mode), done_cyc[d], 2 * N + lat + 1);
            check($sformatf("L%0d_m%0d_done_width", lat, mode), done_w[d], 1);
            check($sformatf("L%0d_m%0d_err_cnt", lat, mode), got_err[d], exp_err);
            check($sformatf("L%0d_m%0d_first_err", lat, mode), got_first[d], exp_first);
            check($sformatf("L%0d_m%0d_pass", lat, mode), got_pass[d], exp_pass);
            check($sformatf("L%0d_m%0d_write_count", lat, mode), wr_cnt[d], N);
            check($sformatf("L%0d_m%0d_write_seq_bad", lat, mode), wr_bad[d], 0);
            check($sformatf("L%0d_m%0d_ce_we_outside", lat, mode), viol[d], 0);
            check($sformatf("L%0d_m%0d_err_hold", lat, mode), err_cnt[d], exp_err);
            check($sformatf("L%0d_m%0d_pass_hold", lat, mode), pass[d], exp_pass);
            check($sformatf("L%0d_m%0d_idle_after", lat, mode), cstate[d], 5'b00001);
        end
    endtask

    task automatic reset_mid_run();
        int seen;
        seen = 0;
        f_kind = 0;
        @(negedge clk);
        mode_i = 2'd0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int i = 0; i < 400 && seen == 0; i++) begin
            @(negedge clk);
            if (cstate[0] == 5'b00010 && addr[0] == 8'h80) seen = 1;
        end
        check("rst_reach_write_0x80", seen, 1);
        rst_i = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_mid_cstate_%0d", d), cstate[d], 5'b00001);
            check($sformatf("rst_mid_ce_%0d", d), ce[d], 0);
            check($sformatf("rst_mid_we_%0d", d), we[d], 0);
            check($sformatf("rst_mid_busy_%0d", d), busy[d], 0);
        end
        rst_i = 1'b0;
    endtask

`ifdef RAM_BIST_ABORT_EN
    task automatic abort_test();
        int seen;
        int ce_seen;
        seen = 0;
        ce_seen = 0;
        f_kind = 0;
        @(negedge clk);
        mode_i = 2'd0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int i = 0; i < 600 && seen == 0; i++) begin
            @(negedge clk);
            if (cstate[0] == 5'b00100 && addr[0] == 8'h10) seen = 1;
        end
        check("abort_reach_read_0x10", seen, 1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("abort_done_%0d", d), done[d], 1);
            check($sformatf("abort_pass_%0d", d), pass[d], 0);
            check($sformatf("abort_ce_%0d", d), ce[d], 0);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ce[0] || ce[1] || done[0] || done[1]) ce_seen++;
        end
        check("abort_quiet_after", ce_seen, 0);
        check("abort_idle_after", cstate[0], 5'b00001);
    endtask
`endif

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        mode_i = 2'd0;
`ifdef RAM_BIST_ABORT_EN
        abort_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_cstate_%0d", d), cstate[d], 5'b00001);
            check($sformatf("reset_flags_%0d", d), {busy[d], done[d], pass[d], ce[d], we[d]}, 0);
            check($sformatf("reset_err_%0d", d), err_cnt[d], 0);
            check($sformatf("reset_first_%0d", d), first_err[d], 0);
            check($sformatf("reset_addr_%0d", d), addr[d], 0);
            check($sformatf("reset_wdata_%0d", d), wdata[d], 0);
        end
        rst_i = 1'b0;

        run_test(2'd0, 0, 8'h00, 3'd0, 1'b0, 1'b0);
        run_test(2'd3, 1, 8'h3C, 3'd2, 1'b0, 1'b0);
        run_test(2'd0, 2, 8'h00, 3'd0, 1'b0, 1'b0);
        run_test(2'd2, 0, 8'h00, 3'd0, 1'b0, 1'b0);
        reset_mid_run();
        run_test(2'd1, 0, 8'h00, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_test(2'($urandom), int'($urandom_range(0, 2)), 8'($urandom), 3'($urandom),
                     1'($urandom), 1'($urandom));
        end
`ifdef RAM_BIST_ABORT_EN
        abort_test();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Built-in self-test sequencer for the on-chip single-port RAM (256x8 by default) used by the RAM test block.
- Fills the RAM with a selectable pattern, reads it back, compares every word against the regenerated expected value, and reports pass/fail, error count and first failing address.
- Exposes its one-hot state vector so it can be probed by the embedded logic analyser.

Parameters:
- ADDR_W, 8, RAM address width; sequence covers 0 .. 2^ADDR_W-1.
- DATA_W, 8, RAM data width; must be >= 8.
- RD_LAT, 1, RAM read latency in clocks (1..4), from ce/addr to valid ram_rdata_i.
- SEED, 8'hA5, LFSR seed for mode 2; must be nonzero.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start request; sampled only in IDLE.
- mode_i  in  2  pattern select, latched at start: 0 address, 1 inverted address, 2 LFSR, 3 checkerboard.
- busy_o  out  1  high in WRITE, READ, DRAIN, DONE.
- done_o  out  1  one-cycle pulse in DONE.
- pass_o  out  1  1 when the last completed run had err_cnt_o==0.
- err_cnt_o  out  ADDR_W  mismatch count, saturating at all-ones.
- first_err_addr_o  out  ADDR_W  address of the first mismatch in the run.
- ram_ce_o  out  1  RAM chip enable.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_wdata_o  out  DATA_W  RAM write data.
- ram_rdata_i  in  DATA_W  RAM read data.
- cstate_o  out  5  one-hot state: bit0 IDLE, bit1 WRITE, bit2 READ, bit3 DRAIN, bit4 DONE.

Behaviour:
- Reset values: cstate_o=5'b00001; busy_o, done_o, pass_o, ram_ce_o, ram_we_o = 0; err_cnt_o, first_err_addr_o, ram_addr_o, ram_wdata_o = 0.
- rst_i at any time, including mid-run, returns to IDLE on the next edge. No partial result is retained.
- IDLE:
  - start_i=1 latches mode_i, clears err_cnt_o, pass_o and first_err_addr_o, loads the LFSR with SEED, and enters WRITE with addr=0.
  - start_i is ignored in every state other than IDLE.
- WRITE:
  - Each cycle drives ce=1, we=1, ram_addr_o=addr and ram_wdata_o=pattern(addr).
  - addr increments each cycle.
  - After the write to the last address, enters READ with addr=0 and the LFSR reloaded with SEED.
- READ:
  - Each cycle drives ce=1, we=0, ram_addr_o=addr; addr increments.
  - The expected value and addr enter an RD_LAT-deep shift pipeline together with a valid bit.
  - After the last address is issued, enters DRAIN.
- DRAIN: ce=0. Holds for exactly RD_LAT cycles so the pipeline empties, then enters DONE.
- Compare:
  - Whenever a pipeline-output valid bit is set, ram_rdata_i is compared with the expected value.
  - On mismatch, err_cnt_o increments, saturating at 2^ADDR_W-1.
  - If this is the first mismatch of the run, first_err_addr_o is loaded with the pipelined address.
- DONE:
  - done_o=1, pass_o <= (err_cnt_o==0); err_cnt_o includes the final compare.
  - Enters IDLE next cycle. Results hold until the next start.
- Timing: start sampled at edge 0 -> done_o high in cycle 2*2^ADDR_W + RD_LAT + 1 (514 for the defaults).
- Patterns (upper DATA_W-8 bits are zero for modes 2/3):
  - Mode 0: addr zero-extended or truncated to DATA_W.
  - Mode 1: bitwise inverse of mode 0.
  - Mode 2: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advanced once per word.
  - Mode 3: 8'h55 for even addr, 8'hAA for odd addr.
- ram_we_o is never high outside WRITE; ram_ce_o is never high outside WRITE/READ.

Optional Feature:
- Macro: RAM_BIST_ABORT_EN.
- Defined: adds input abort_i (1 bit). abort_i=1 in WRITE, READ or DRAIN enters DONE on the next edge, with ce/we dropped, the pipeline flushed and pass_o forced to 0. abort_i is ignored in IDLE and DONE.
- Undefined: no abort_i port; a run always completes.

Test Plan:
- Ideal RAM model (RD_LAT=1), mode 0, one start pulse -> done_o at cycle 514, err_cnt_o=0, pass_o=1, writes observed as addr N / data N.
- RAM model with bit 2 stuck-at-0 at address 0x3C, mode 3 -> err_cnt_o=1, first_err_addr_o=0x3C, pass_o=0.
- RAM model always returning 0xFF, mode 0 -> err_cnt_o=255 (address 0xFF matches), first_err_addr_o=0x00, pass_o=0.
- Mode 2 with RD_LAT=3 -> first writes 0xA5 then the next LFSR values; read compares are aligned; err_cnt_o=0; done_o at cycle 516.
- rst_i asserted at WRITE addr 0x80, start again afterwards -> cstate_o=00001 and ce/we=0 the cycle after reset; a fresh run passes; start_i pulses during busy are ignored.
- With RAM_BIST_ABORT_EN: abort_i at READ addr 0x10 -> done_o next cycle, pass_o=0, ce=0 thereafter.
